// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - sequenced arithmetic unit: single-cycle logic/add/sub, shift-add multiply
// Operands and opcode are latched on an accepted start; result/carry update only on the done pulse.
module arith_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       switches,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_q, b_q, b_sh;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc, mcand, acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic               accept, finish;
  logic [WIDTH-1:0]   res_next;
  logic               carry_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = (switches[2] && switches[1]) ? MUL : EXEC;
      end
      EXEC: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      MUL: if (cnt == LAST_ITER) begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // acc_sum is the product after the current iteration, so the final MUL edge can write it directly.
  always_comb begin
    sum_ext    = {1'b0, a_q} + {1'b0, b_q};
    diff_ext   = {1'b0, a_q} - {1'b0, b_q};
    acc_sum    = acc + (b_sh[0] ? mcand : '0);
    res_next   = '0;
    carry_next = 1'b0;
    case (op_q)
      3'b000: res_next = ~a_q;
      3'b001: res_next = ~b_q;
      3'b010: {carry_next, res_next} = sum_ext;
      3'b011: {carry_next, res_next} = diff_ext;
      3'b100: res_next = a_q & b_q;
      3'b101: res_next = a_q | b_q;
      3'b110: begin
        res_next   = acc_sum[WIDTH-1:0];
        carry_next = |acc_sum[2*WIDTH-1:WIDTH];
      end
      default: res_next = acc_sum[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= OpA;
        b_q   <= OpB;
        op_q  <= switches;
        busy  <= 1'b1;
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, OpA};
        b_sh  <= OpB;
        cnt   <= '0;
      end
      if (state == MUL) begin
        acc   <= acc_sum;
        mcand <= mcand << 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        result <= res_next;
        carry  <= carry_next;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule
